// File: rtl/alu_multiword_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared types for the multi-word ALU sequencer.
//   unit_e  : ALU unit / flag-select code driven onto the ALU.
//   state_e : sequencer FSM states.
//   flags_t : aggregated response flags {cf, zf, of, sf, pf}.
//   OP_*    : block op codes, mirrored from the ALU package encoding.
// -----------------------------------------------------------------------------
package alu_seq_pkg;

  typedef enum logic [1:0] {
    ARITH  = 2'd0,
    LOGIC  = 2'd1,
    LSHIFT = 2'd2,
    RSHIFT = 2'd3
  } unit_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic cf;
    logic zf;
    logic of;
    logic sf;
    logic pf;
  } flags_t;

  // Arithmetic block ops (SUB is A + ~B + carry, carry = not-borrow)
  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  // Logic block ops
  localparam logic [1:0] OP_AND  = 2'd0;
  localparam logic [1:0] OP_OR   = 2'd1;
  localparam logic [1:0] OP_XOR  = 2'd2;
  localparam logic [1:0] OP_NAND = 2'd3;

endpackage : alu_seq_pkg

// File: rtl/alu_multiword_sequencer_slicer.sv
// -----------------------------------------------------------------------------
// alu_word_slicer
// Combinational word select for the multi-word sequencer.
//   a_i, b_i   : full operands, LSW at bit 0.
//   idx_i      : word index being processed.
//   msw_i      : index of the most significant word of the operation.
//   unit_i     : selects which neighbour feeds the shift-in bits.
//   a_word_o   : A word[idx].
//   b_word_o   : B word[idx].
//   c_o        : shift-in bits for the current word
//                LSHIFT: A word[idx-1][WW-1:1], 0 at idx 0
//                RSHIFT: A word[idx+1][WW-2:0], 0 at the MSW
//                others: 0
// -----------------------------------------------------------------------------
module alu_word_slicer
  import alu_seq_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned MAX_WORDS  = 4,
  localparam int unsigned CNT_W     = $clog2(MAX_WORDS)
) (
  input  logic [MAX_WORDS*WORD_WIDTH-1:0] a_i,
  input  logic [MAX_WORDS*WORD_WIDTH-1:0] b_i,
  input  logic [CNT_W-1:0]                idx_i,
  input  logic [CNT_W-1:0]                msw_i,
  input  unit_e                           unit_i,
  output logic [WORD_WIDTH-1:0]           a_word_o,
  output logic [WORD_WIDTH-1:0]           b_word_o,
  output logic [WORD_WIDTH-2:0]           c_o
);

  logic [WORD_WIDTH-1:0] a_w [MAX_WORDS];
  logic [WORD_WIDTH-1:0] b_w [MAX_WORDS];
  logic [CNT_W-1:0]      idx_prev;
  logic [CNT_W-1:0]      idx_next;

  for (genvar g = 0; g < MAX_WORDS; g++) begin : g_split
    assign a_w[g] = a_i[g*WORD_WIDTH +: WORD_WIDTH];
    assign b_w[g] = b_i[g*WORD_WIDTH +: WORD_WIDTH];
  end

  // Neighbour indices wrap at the ends; the wrapped word is never used
  // because the edge cases force c_o to zero.
  assign idx_prev = idx_i - 1'b1;
  assign idx_next = idx_i + 1'b1;

  assign a_word_o = a_w[idx_i];
  assign b_word_o = b_w[idx_i];

  always_comb begin
    c_o = '0;
    case (unit_i)
      LSHIFT: if (idx_i != '0)    c_o = a_w[idx_prev][WORD_WIDTH-1:1];
      RSHIFT: if (idx_i != msw_i) c_o = a_w[idx_next][WORD_WIDTH-2:0];
      default: c_o = '0;
    endcase
  end

endmodule : alu_word_slicer

// File: rtl/alu_multiword_sequencer.sv
// -----------------------------------------------------------------------------
// alu_multiword_sequencer
// Initiator side of the ALU operand/flag interface. Accepts a 1..MAX_WORDS
// word operation, drives one ALU word per cycle with chained carry and
// shift-in bits, and returns the assembled result with aggregated flags.
//   clk_i, rst_ni              : clock, async active-low reset
//   req_valid_i / req_ready_o  : request handshake (ready only in IDLE)
//   req_unit_i, req_op_i       : ALU unit and block op
//   req_words_i                : word count minus 1
//   req_cf_i                   : initial carry
//   req_a_i, req_b_i           : operands, LSW at bit 0
//   alu_select_flags_o, alu_op_o, alu_a_o, alu_b_o, alu_c_o, alu_cf_o
//                              : ALU drive, zero outside RUN
//   alu_*_r_i, alu_*f_i        : ALU block results and selected flags
//   rsp_valid_o / rsp_ready_i  : response handshake (valid only in DONE)
//   rsp_r_o, rsp_*f_o          : result and aggregated flags
// -----------------------------------------------------------------------------
module alu_multiword_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned MAX_WORDS  = 4,
  localparam int unsigned CNT_W     = $clog2(MAX_WORDS)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic [1:0]                      req_unit_i,
  input  logic [1:0]                      req_op_i,
  input  logic [CNT_W-1:0]                req_words_i,
  input  logic                            req_cf_i,
  input  logic [MAX_WORDS*WORD_WIDTH-1:0] req_a_i,
  input  logic [MAX_WORDS*WORD_WIDTH-1:0] req_b_i,
  output logic [1:0]                      alu_select_flags_o,
  output logic [1:0]                      alu_op_o,
  output logic [WORD_WIDTH-1:0]           alu_a_o,
  output logic [WORD_WIDTH-1:0]           alu_b_o,
  output logic [WORD_WIDTH-2:0]           alu_c_o,
  output logic                            alu_cf_o,
  input  logic [WORD_WIDTH-1:0]           alu_ab_r_i,
  input  logic [WORD_WIDTH-1:0]           alu_lb_r_i,
  input  logic [WORD_WIDTH-1:0]           alu_lsb_r_i,
  input  logic [WORD_WIDTH-1:0]           alu_rsb_r_i,
  input  logic                            alu_cf_i,
  input  logic                            alu_zf_i,
  input  logic                            alu_of_i,
  input  logic                            alu_sf_i,
  input  logic                            alu_pf_i,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic [MAX_WORDS*WORD_WIDTH-1:0] rsp_r_o,
  output logic                            rsp_cf_o,
  output logic                            rsp_zf_o,
  output logic                            rsp_of_o,
  output logic                            rsp_sf_o,
  output logic                            rsp_pf_o
);

  localparam int unsigned TOT_W = MAX_WORDS * WORD_WIDTH;

  state_e                state_q, state_d;
  unit_e                 unit_q,  unit_d;
  logic [1:0]            op_q,    op_d;
  logic [CNT_W-1:0]      words_q, words_d;
  logic [CNT_W-1:0]      idx_q,   idx_d;
  logic                  cf_q,    cf_d;
  logic [TOT_W-1:0]      a_q,     a_d;
  logic [TOT_W-1:0]      b_q,     b_d;
  logic [TOT_W-1:0]      r_q,     r_d;
  flags_t                flags_q, flags_d;

  logic [WORD_WIDTH-1:0] a_word;
  logic [WORD_WIDTH-1:0] b_word;
  logic [WORD_WIDTH-2:0] c_bits;
  logic [WORD_WIDTH-1:0] res_word;
  logic                  run;
  logic                  last_word;
  unit_e                 req_unit;

  assign req_unit = unit_e'(req_unit_i);
  assign run      = (state_q == RUN);

  alu_word_slicer #(
    .WORD_WIDTH (WORD_WIDTH),
    .MAX_WORDS  (MAX_WORDS)
  ) u_slicer (
    .a_i      (a_q),
    .b_i      (b_q),
    .idx_i    (idx_q),
    .msw_i    (words_q),
    .unit_i   (unit_q),
    .a_word_o (a_word),
    .b_word_o (b_word),
    .c_o      (c_bits)
  );

  // Result of the current word comes from the block matching the unit
  always_comb begin
    res_word = '0;
    case (unit_q)
      ARITH:   res_word = alu_ab_r_i;
      LOGIC:   res_word = alu_lb_r_i;
      LSHIFT:  res_word = alu_lsb_r_i;
      RSHIFT:  res_word = alu_rsb_r_i;
      default: res_word = '0;
    endcase
  end

  // Right shifts walk MSW -> LSW so each word sees the carry-out of the
  // word above it; everything else walks LSW -> MSW.
  assign last_word = (unit_q == RSHIFT) ? (idx_q == '0) : (idx_q == words_q);

  always_comb begin
    state_d = state_q;
    unit_d  = unit_q;
    op_d    = op_q;
    words_d = words_q;
    idx_d   = idx_q;
    cf_d    = cf_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    flags_d = flags_q;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          unit_d     = req_unit;
          op_d       = req_op_i;
          words_d    = req_words_i;
          cf_d       = req_cf_i;
          a_d        = req_a_i;
          b_d        = req_b_i;
          r_d        = '0;
          flags_d    = '0;
          // zf is an AND over all words, so it starts from 1
          flags_d.zf = 1'b1;
          idx_d      = (req_unit == RSHIFT) ? req_words_i : '0;
          state_d    = RUN;
        end
      end

      RUN: begin
        for (int unsigned w = 0; w < MAX_WORDS; w++) begin
          if (idx_q == CNT_W'(w)) begin
            r_d[w*WORD_WIDTH +: WORD_WIDTH] = res_word;
          end
        end
        cf_d       = alu_cf_i;
        flags_d.cf = alu_cf_i;
        flags_d.zf = flags_q.zf & alu_zf_i;
        if (idx_q == words_q) begin
          flags_d.of = alu_of_i;
          flags_d.sf = alu_sf_i;
        end
        if (idx_q == '0) begin
          flags_d.pf = alu_pf_i;
        end
        if (last_word) begin
          state_d = DONE;
        end else if (unit_q == RSHIFT) begin
          idx_d = idx_q - 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DONE: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      unit_q  <= ARITH;
      op_q    <= '0;
      words_q <= '0;
      idx_q   <= '0;
      cf_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      unit_q  <= unit_d;
      op_q    <= op_d;
      words_q <= words_d;
      idx_q   <= idx_d;
      cf_q    <= cf_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      flags_q <= flags_d;
    end
  end

  assign req_ready_o        = (state_q == IDLE);
  assign rsp_valid_o        = (state_q == DONE);

  assign alu_select_flags_o = run ? unit_q : '0;
  assign alu_op_o           = run ? op_q   : '0;
  assign alu_a_o            = run ? a_word : '0;
  assign alu_b_o            = run ? b_word : '0;
  assign alu_c_o            = run ? c_bits : '0;
  assign alu_cf_o           = run ? cf_q   : 1'b0;

  assign rsp_r_o            = r_q;
  assign rsp_cf_o           = flags_q.cf;
  assign rsp_zf_o           = flags_q.zf;
  assign rsp_of_o           = flags_q.of;
  assign rsp_sf_o           = flags_q.sf;
  assign rsp_pf_o           = flags_q.pf;

endmodule : alu_multiword_sequencer
